// File: rtl/led_pkg.sv
// Shared definitions for the LED front-end: mode encodings, widths and timing defaults.
package led_pkg;

    localparam int CLK_HZ           = 27000000;
    localparam int MODE_W           = 2;
    localparam int DEBOUNCE_CYC_DEF = CLK_HZ / 50;   // 20 ms
    localparam int AUTO_CYC_DEF     = CLK_HZ * 5;    // 5 s

    typedef enum logic [MODE_W-1:0] {
        MODE_RUN_H2L  = 2'd0,
        MODE_RUN_L2H  = 2'd1,
        MODE_FILL_H2L = 2'd2
    } mode_t;

    // Step forward/backward through the three modes; any illegal code lands on MODE_RUN_H2L.
    function automatic mode_t mode_fwd(input mode_t m);
        case (m)
            MODE_RUN_H2L: return MODE_RUN_L2H;
            MODE_RUN_L2H: return MODE_FILL_H2L;
            default:      return MODE_RUN_H2L;
        endcase
    endfunction

    function automatic mode_t mode_back(input mode_t m);
        case (m)
            MODE_RUN_H2L:  return MODE_FILL_H2L;
            MODE_FILL_H2L: return MODE_RUN_L2H;
            default:       return MODE_RUN_H2L;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single active-low key: two-flop synchroniser, stability filter and registered press pulse.
module key_debounce
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_stable,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_reg, sync2_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             stable_reg, stable_next;
    logic             stable_d_reg;
    logic             press_reg;

    // The counter only runs while the synchronised level disagrees with the accepted level.
    always_comb begin
        cnt_next    = '0;
        stable_next = stable_reg;
        if (sync2_reg != stable_reg) begin
            if (cnt_reg == CNT_LAST) begin
                stable_next = sync2_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            cnt_reg      <= '0;
            stable_reg   <= 1'b1;
            stable_d_reg <= 1'b1;
            press_reg    <= 1'b0;
        end else begin
            sync1_reg    <= key_raw;
            sync2_reg    <= sync1_reg;
            cnt_reg      <= cnt_next;
            stable_reg   <= stable_next;
            stable_d_reg <= stable_reg;
            press_reg    <= stable_d_reg & ~stable_reg;
        end
    end

    assign key_stable = stable_reg;
    assign press      = press_reg;

endmodule

// File: rtl/key_mode_ctrl.sv
// Key front-end and mode FSM driving the LED pattern select; define AUTO_CYCLE_EN to
// add an idle timer that advances the mode automatically after AUTO_CYC quiet cycles.
module key_mode_ctrl
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int AUTO_CYC     = AUTO_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        key,
    output logic [MODE_W-1:0] ctrl,
    output logic              mode_chg,
    output logic [1:0]        key_stable
);

    logic [1:0] press;
    logic       auto_tick;
    mode_t      mode_reg, mode_next;
    logic       chg_reg, chg_next;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_debounce (
                .clk        (clk),
                .rst_n      (rst_n),
                .key_raw    (key[gi]),
                .key_stable (key_stable[gi]),
                .press      (press[gi])
            );
        end
    endgenerate

`ifdef AUTO_CYCLE_EN
    localparam logic [27:0] TIMER_LAST = 28'(AUTO_CYC - 1);

    logic [27:0] timer_reg, timer_next;

    // A press always restarts the idle period, even when it lands on the terminal count.
    always_comb begin
        timer_next = timer_reg + 28'd1;
        auto_tick  = 1'b0;
        if (|press) begin
            timer_next = '0;
        end else if (timer_reg == TIMER_LAST) begin
            timer_next = '0;
            auto_tick  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_next;
        end
    end
`else
    assign auto_tick = 1'b0;
`endif

    always_comb begin
        mode_next = mode_reg;
        if (!(mode_reg inside {MODE_RUN_H2L, MODE_RUN_L2H, MODE_FILL_H2L})) begin
            mode_next = MODE_RUN_H2L;
        end
        case (press)
            2'b11:   mode_next = MODE_RUN_H2L;
            2'b01:   mode_next = mode_fwd(mode_reg);
            2'b10:   mode_next = mode_back(mode_reg);
            default: if (auto_tick) mode_next = mode_fwd(mode_reg);
        endcase
        chg_next = (mode_next != mode_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg <= MODE_RUN_H2L;
            chg_reg  <= 1'b0;
        end else begin
            mode_reg <= mode_next;
            chg_reg  <= chg_next;
        end
    end

    assign ctrl     = mode_reg;
    assign mode_chg = chg_reg;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Self-checking bench for key_mode_ctrl with a window-based key model and modular mode arithmetic.
module tb_key_mode_ctrl;

    localparam int D = 8;
    localparam int A = 64;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key   = 2'b11;
    logic [1:0] ctrl;
    logic       mode_chg;
    logic [1:0] key_stable;

    int n_chk  = 0;
    int n_err  = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    key_mode_ctrl #(
        .DEBOUNCE_CYC (D),
        .AUTO_CYC     (A)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .ctrl       (ctrl),
        .mode_chg   (mode_chg),
        .key_stable (key_stable)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a key level is accepted once D consecutive synchronised samples all disagree
    // with the current accepted level; the resulting press reaches ctrl two cycles later.
    bit win [2][D+2];
    int m_stable [2] = '{1, 1};
    int m_ctrl   = 0;
    int m_chg    = 0;
    int m_press  = 0;
    int m_fall   = 0;
    int m_cyc    = 0;
    int last_evt = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < D + 2; j++) win[k][j] = 1'b1;
                m_stable[k] = 1;
            end
            m_ctrl = 0; m_chg = 0; m_press = 0; m_fall = 0;
            m_cyc = 0; last_evt = 0;
        end else begin
            int old_ctrl;
            bit auto_now;
            m_cyc++;
            for (int k = 0; k < 2; k++) begin
                for (int j = D + 1; j > 0; j--) win[k][j] = win[k][j-1];
                win[k][0] = key[k];
            end
            old_ctrl = m_ctrl;
            auto_now = 1'b0;
`ifdef AUTO_CYCLE_EN
            auto_now = (m_cyc - last_evt == A);
`endif
            if (m_press == 3)      m_ctrl = 0;
            else if (m_press == 1) m_ctrl = (m_ctrl + 1) % 3;
            else if (m_press == 2) m_ctrl = (m_ctrl + 2) % 3;
            else if (auto_now)     m_ctrl = (m_ctrl + 1) % 3;
            if (m_press != 0 || auto_now) last_evt = m_cyc;
            m_chg   = (m_ctrl != old_ctrl) ? 1 : 0;
            m_press = m_fall;
            m_fall  = 0;
            for (int k = 0; k < 2; k++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int j = 2; j < D + 2; j++)
                    if (int'(win[k][j]) == m_stable[k]) all_diff = 1'b0;
                if (all_diff) begin
                    if (m_stable[k] == 1) m_fall = m_fall | (1 << k);
                    m_stable[k] = 1 - m_stable[k];
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("ctrl", int'(ctrl), m_ctrl);
            chk("mode_chg", int'(mode_chg), m_chg);
            chk("key_stable", int'(key_stable), m_stable[1] * 2 + m_stable[0]);
        end
    end

    // Called at a negedge: press the masked keys, check the exact 12-cycle latency, release.
    task automatic press_check(input string nm, input logic [1:0] mask, input int low_len,
                               input int exp_ctrl, input int exp_chg);
        key = key & ~mask;
        repeat (11) @(negedge clk);
        chk({nm, "_early"}, int'(mode_chg), 0);
        @(negedge clk);
        chk({nm, "_chg"}, int'(mode_chg), exp_chg);
        chk({nm, "_ctrl"}, int'(ctrl), exp_ctrl);
        @(negedge clk);
        chk({nm, "_pulse1"}, int'(mode_chg), 0);
        $display("press %s keys=%b ctrl=%0d", nm, mask, ctrl);
        repeat (low_len - 13) @(negedge clk);
        key = key | mask;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        int exp_seq [3];
        exp_seq = '{1, 2, 0};
        rst_n = 1'b0;
        key   = 2'b11;
        @(negedge clk);
        chk("rst_ctrl", int'(ctrl), 0);
        chk("rst_chg", int'(mode_chg), 0);
        chk("rst_key_stable", int'(key_stable), 3);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

`ifdef AUTO_CYCLE_EN
        while (m_cyc < 63) @(negedge clk);
        chk("auto_pre64", int'(ctrl), 0);
        @(negedge clk);
        chk("auto_64_ctrl", int'(ctrl), 1);
        chk("auto_64_chg", int'(mode_chg), 1);
        $display("auto advance at cycle %0d ctrl=%0d", m_cyc, ctrl);
        while (m_cyc < 128) @(negedge clk);
        chk("auto_128_ctrl", int'(ctrl), 2);
        $display("auto advance at cycle %0d ctrl=%0d", m_cyc, ctrl);
        while (m_cyc < 180) @(negedge clk);
        key[1] = 1'b0;
        while (m_cyc < 191) @(negedge clk);
        chk("tc_pre_ctrl", int'(ctrl), 2);
        @(negedge clk);
        chk("tc_press_ctrl", int'(ctrl), 1);
        chk("tc_press_chg", int'(mode_chg), 1);
        $display("press on terminal count at cycle %0d ctrl=%0d", m_cyc, ctrl);
        while (m_cyc < 200) @(negedge clk);
        key[1] = 1'b1;
        while (m_cyc < 255) @(negedge clk);
        chk("tc_after_ctrl", int'(ctrl), 1);
        @(negedge clk);
        chk("auto_256_ctrl", int'(ctrl), 2);
        chk("auto_256_chg", int'(mode_chg), 1);
        $display("auto advance at cycle %0d ctrl=%0d", m_cyc, ctrl);
        repeat (5) @(negedge clk);
`else
        repeat (100) @(negedge clk);
        chk("idle_ctrl", int'(ctrl), 0);
        chk("idle_key_stable", int'(key_stable), 3);
        $display("idle 100 cycles ctrl=%0d", ctrl);

        for (int i = 0; i < 3; i++) press_check("next", 2'b01, 20, exp_seq[i], 1);

        key[1] = 1'b0;
        repeat (5) @(negedge clk);
        key[1] = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_ctrl", int'(ctrl), 0);
        chk("glitch_key_stable", int'(key_stable), 3);
        $display("glitch on prev ctrl=%0d", ctrl);
        press_check("prev", 2'b10, 20, 2, 1);

        press_check("next", 2'b01, 20, 0, 1);
        press_check("next", 2'b01, 20, 1, 1);
        press_check("both", 2'b11, 20, 0, 1);
        press_check("both_at0", 2'b11, 20, 0, 0);

        press_check("next", 2'b01, 20, 1, 1);
        key[0] = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", int'(ctrl), 0);
        chk("midrst_chg", int'(mode_chg), 0);
        chk("midrst_key_stable", int'(key_stable), 3);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (11) @(negedge clk);
        chk("postrst_early", int'(mode_chg), 0);
        @(negedge clk);
        chk("postrst_chg", int'(mode_chg), 1);
        chk("postrst_ctrl", int'(ctrl), 1);
        $display("reset mid-debounce, held key stepped ctrl=%0d", ctrl);
        key[0] = 1'b1;
        repeat (30) @(negedge clk);

        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        chk("hold1000_ctrl", int'(ctrl), 0);
        $display("no auto advance over 1000 cycles ctrl=%0d", ctrl);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
